// File: rtl/core_pkg.sv
// Shared core constants: default data width, byte-offset bits, word slicing.
// Imported by the store buffer top and its match sub-module.
package core_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int WORD_OFF   = 2;

  function automatic logic [DWIDTH_DEF-WORD_OFF-1:0] word_addr(
    input logic [DWIDTH_DEF-1:0] a
  );
    return a[DWIDTH_DEF-1:WORD_OFF];
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Load snoop: DEPTH-way word compare, youngest-first select, tail-1 match.
// In: valid_i, addr_i, data_i, head_i, tail_i, ld_word_i, st_word_i.
// Out: ld_hit_o, ld_data_o, yng_match_o (youngest entry == st_word_i).
module store_buffer_match
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = DWIDTH_DEF - WORD_OFF,
  parameter int DW    = DWIDTH_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][AW-1:0] addr_i,
  input  logic [DEPTH-1:0][DW-1:0] data_i,
  input  logic [PW-1:0]            head_i,
  input  logic [PW-1:0]            tail_i,
  input  logic [AW-1:0]            ld_word_i,
  input  logic [AW-1:0]            st_word_i,
  output logic                     ld_hit_o,
  output logic [DW-1:0]            ld_data_o,
  output logic                     yng_match_o
);

  logic [PW-1:0] idx;
  logic [PW-1:0] yng_idx;

  // Walk oldest to youngest; later hits override earlier ones.
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (valid_i[idx] && (addr_i[idx] == ld_word_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_i[idx];
      end
    end
  end

  assign yng_idx     = tail_i - PW'(1);
  assign yng_match_o = valid_i[yng_idx] &&
                       (addr_i[yng_idx] == st_word_i);

endmodule

// File: rtl/store_buffer.sv
// In-order word store queue draining to memory over req/ack; loads snoop it.
// Ports: clk, rst (sync, active-high); st_valid/st_addr/st_wdata/st_ready;
// ld_addr/ld_hit/ld_data; mem_req/mem_addr/mem_wdata/mem_ack; sb_empty,
// sb_count. Optional macro STORE_COALESCE_EN merges a store into the
// youngest entry when its word matches (never the head entry).
module store_buffer
  import core_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [DWIDTH-1:0]        st_addr,
  input  logic [DWIDTH-1:0]        st_wdata,
  output logic                     st_ready,
  input  logic [DWIDTH-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DWIDTH-1:0]        ld_data,
  output logic                     mem_req,
  output logic [DWIDTH-1:0]        mem_addr,
  output logic [DWIDTH-1:0]        mem_wdata,
  input  logic                     mem_ack,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = DWIDTH - WORD_OFF;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0]     addr_q;
  logic [DEPTH-1:0][DWIDTH-1:0] data_q;
  logic [PW-1:0]                head_q, head_d;
  logic [PW-1:0]                tail_q, tail_d;
  logic [CW-1:0]                count_q, count_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          coal;
  logic          yng_match;
  logic [PW-1:0] yng_idx;
  logic [AW-1:0] st_word;
  logic [AW-1:0] ld_word;
  logic          unused_lo;

  assign st_word   = st_addr[DWIDTH-1:WORD_OFF];
  assign ld_word   = ld_addr[DWIDTH-1:WORD_OFF];
  assign unused_lo = ^{st_addr[WORD_OFF-1:0], ld_addr[WORD_OFF-1:0]};
  assign yng_idx   = tail_q - PW'(1);

  store_buffer_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DWIDTH),
    .PW    (PW)
  ) u_match (
    .valid_i     (valid_q),
    .addr_i      (addr_q),
    .data_i      (data_q),
    .head_i      (head_q),
    .tail_i      (tail_q),
    .ld_word_i   (ld_word),
    .st_word_i   (st_word),
    .ld_hit_o    (ld_hit),
    .ld_data_o   (ld_data),
    .yng_match_o (yng_match)
  );

`ifdef STORE_COALESCE_EN
  // count>=2 keeps the head (under mem_req) out of reach.
  assign coal = st_valid && (count_q >= CW'(2)) && yng_match;
`else
  logic unused_yng;
  assign unused_yng = yng_match;
  assign coal       = 1'b0;
`endif

  assign full      = (count_q == CW'(DEPTH));
  assign st_ready  = !full || coal;
  assign push      = st_valid && st_ready && !coal;
  assign mem_req   = (count_q != '0);
  assign pop       = mem_req && mem_ack;
  assign sb_empty  = (count_q == '0);
  assign sb_count  = count_q;
  assign mem_addr  = {addr_q[head_q], {WORD_OFF{1'b0}}};
  assign mem_wdata = data_q[head_q];

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_word;
      data_q[tail_q] <= st_wdata;
    end else if (coal) begin
      data_q[yng_idx] <= st_wdata;
    end
  end

endmodule
